// File: rtl/fifo_rr_drain_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler family.
package fifo_sched_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t XFER = 1'b1;

  localparam int unsigned DBG_WID = 32;

  // Ceiling log2, used to size port indices from a port count.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_sched_if.sv
// FIFO read-port bank plus downstream valid/ready stream seen by the scheduler.
interface fifo_rr_drain_sched_if #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned DWID  = 18,
  parameter int unsigned PWID  = 2
) ();

  logic [NPORT-1:0]      fifo_nempty;
  logic [NPORT-1:0]      fifo_ren;
  logic [NPORT*DWID-1:0] fifo_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DWID-1:0]       out_data;
  logic [PWID-1:0]       out_port;

  modport master (
    input  fifo_nempty, fifo_rdata, out_ready,
    output fifo_ren, out_valid, out_data, out_port
  );

  modport slave (
    output fifo_nempty, fifo_rdata, out_ready,
    input  fifo_ren, out_valid, out_data, out_port
  );

endinterface

// File: rtl/fifo_rr_drain_sched_rr_pick.sv
// Rotating-priority encoder: first set req bit after 'last', wrapping modulo NPORT.
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NPORT = 4,
  parameter int unsigned PWID  = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PWID-1:0]  last,
  output logic             found,
  output logic [PWID-1:0]  idx
);

  logic [PWID-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NPORT; k >= 1; k--) begin
      cand = PWID'((32'(last) + 32'(k)) % NPORT);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain_sched.sv
// Packet-aware round-robin drain of NPORT show-ahead FIFOs into one registered stream.
module fifo_rr_drain_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NPORT   = 4,
  parameter int unsigned DWID    = 18,
  parameter int unsigned EOP_BIT = 16,
  parameter int unsigned PWID    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_rr_drain_sched_if.master sif,
  output logic                 busy,
  output logic [DBG_WID-1:0]   dbg
);

  state_t          state, state_nxt;
  logic [PWID-1:0] cur_gnt, cur_gnt_nxt;
  logic [PWID-1:0] last_gnt, last_gnt_nxt;
  logic            busy_nxt;
  logic [15:0]     pkt_cnt, pkt_cnt_nxt;
  logic            out_valid_q, out_valid_nxt;
  logic [DWID-1:0] out_data_q, out_data_nxt;
  logic [PWID-1:0] out_port_q, out_port_nxt;

  logic            pick_found;
  logic [PWID-1:0] pick_idx;
  logic [DWID-1:0] rd_word [NPORT];
  logic [DWID-1:0] head;
  logic            can_load;
  logic            fire;

  for (genvar i = 0; i < NPORT; i++) begin : g_unpack
    assign rd_word[i] = sif.fifo_rdata[i*DWID +: DWID];
  end

  rr_pick #(.NPORT(NPORT), .PWID(PWID)) u_pick (
    .req   (sif.fifo_nempty),
    .last  (last_gnt),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, grant and output-register control.
  always_comb begin
    state_nxt     = state;
    cur_gnt_nxt   = cur_gnt;
    last_gnt_nxt  = last_gnt;
    busy_nxt      = busy;
    pkt_cnt_nxt   = pkt_cnt;
    out_valid_nxt = out_valid_q;
    out_data_nxt  = out_data_q;
    out_port_nxt  = out_port_q;
    head          = rd_word[cur_gnt];
    can_load      = !out_valid_q || sif.out_ready;
    fire          = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          cur_gnt_nxt = pick_idx;
          state_nxt   = XFER;
          busy_nxt    = 1'b1;
        end
      end
      XFER: begin
        // Grant is held through an empty source; never switch mid-packet.
        fire = sif.fifo_nempty[cur_gnt] && can_load && !rst;
        if (fire) begin
          out_data_nxt  = head;
          out_port_nxt  = cur_gnt;
          out_valid_nxt = 1'b1;
          if (head[EOP_BIT]) begin
            state_nxt    = IDLE;
            last_gnt_nxt = cur_gnt;
            busy_nxt     = 1'b0;
            pkt_cnt_nxt  = pkt_cnt + 16'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (out_valid_q && sif.out_ready && !fire) out_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_gnt     <= '0;
      last_gnt    <= PWID'(NPORT - 1);
      busy        <= 1'b0;
      pkt_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
    end else begin
      state       <= state_nxt;
      cur_gnt     <= cur_gnt_nxt;
      last_gnt    <= last_gnt_nxt;
      busy        <= busy_nxt;
      pkt_cnt     <= pkt_cnt_nxt;
      out_valid_q <= out_valid_nxt;
      out_data_q  <= out_data_nxt;
      out_port_q  <= out_port_nxt;
    end
  end

  assign sif.fifo_ren  = fire ? (NPORT'(1) << cur_gnt) : '0;
  assign sif.out_valid = out_valid_q;
  assign sif.out_data  = out_data_q;
  assign sif.out_port  = out_port_q;
  assign dbg           = {8'(cur_gnt), 8'h00, pkt_cnt};

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// Directed bench for fifo_rr_drain_sched with queue-modelled FIFO sources.
module tb_fifo_rr_drain_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] dbg;

  always #5 clk = ~clk;

  fifo_rr_drain_sched_if #(.NPORT(4), .DWID(18), .PWID(2)) sif ();

  fifo_rr_drain_sched #(.NPORT(4), .DWID(18), .EOP_BIT(16), .PWID(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .sif  (sif),
    .busy (busy),
    .dbg  (dbg)
  );

  logic [17:0] q [4][$];
  logic [19:0] log_q [$];
  logic [19:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;
  int          pops [4];
  logic        rst_v, rdy_v;
  logic [3:0]  s_ren;
  logic        s_valid, s_busy;
  logic [17:0] s_data, last_pop, s_last_pop;
  int          pat [4] = '{1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] word(input int p, input int s, input bit e);
    return {1'b0, e, 4'(p), 12'(s)};
  endfunction

  task automatic pkt(input int p, input int n, input int base, input bit eop_last);
    for (int i = 0; i < n; i++) q[p].push_back(word(p, base + i, eop_last && (i == n - 1)));
  endtask

  task automatic exp_pkt(input int p, input int n, input int base, input bit eop_last);
    for (int i = 0; i < n; i++)
      exp_q.push_back({2'(p), word(p, base + i, eop_last && (i == n - 1))});
  endtask

  task automatic drive();
    logic [3:0]  ne;
    logic [71:0] rd;
    ne = '0;
    rd = '0;
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() != 0) begin
        ne[i]          = 1'b1;
        rd[i*18 +: 18] = q[i][0];
      end
    end
    sif.fifo_nempty = ne;
    sif.fifo_rdata  = rd;
  endtask

  // One clock: apply inputs on the falling edge, sample, log and pop what the next edge consumes.
  task automatic cyc();
    @(negedge clk);
    rst           = rst_v;
    sif.out_ready = rdy_v;
    drive();
    #1;
    s_ren      = sif.fifo_ren;
    s_valid    = sif.out_valid;
    s_data     = sif.out_data;
    s_busy     = busy;
    s_last_pop = last_pop;
    chk("ren_inv", {31'b0, ((s_ren & ~sif.fifo_nempty) == 4'b0) && $onehot0(s_ren)}, 32'd1);
    if (s_valid && !sif.out_ready) chk("bp_ren", 32'(s_ren), 32'd0);
    if (s_valid) chk("out_data", 32'(s_data), 32'(s_last_pop));
    if (!rst && s_valid && sif.out_ready) log_q.push_back({sif.out_port, s_data});
    for (int i = 0; i < 4; i++) begin
      if (s_ren[i]) begin
        last_pop = q[i].pop_front();
        pops[i]++;
      end
    end
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_n"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(tag, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst             = 1'b1;
    rst_v           = 1'b1;
    rdy_v           = 1'b1;
    sif.out_ready   = 1'b1;
    sif.fifo_nempty = '0;
    sif.fifo_rdata  = '0;
    last_pop        = '0;
    for (int i = 0; i < 4; i++) pops[i] = 0;

    // Reset with every port loaded, then round-robin over one 3-word packet per port.
    for (int p = 0; p < 4; p++) begin
      pkt(p, 3, p * 16, 1'b1);
      exp_pkt(p, 3, p * 16, 1'b1);
    end
    repeat (3) cyc();
    chk("rst_ren", 32'(s_ren), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_cnt", 32'(dbg[15:0]), 32'd0);
    rst_v = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      chk("rr_ren", 32'(s_ren), (c % 4 == 0) ? 32'd0 : (32'd1 << (c / 4)));
      if (c == 0) chk("rr_busy0", 32'(s_busy), 32'd0);
      if (c == 1) chk("rr_busy1", 32'(s_busy), 32'd1);
    end
    repeat (3) cyc();
    cmp_log("rr");
    chk("rr_cnt", 32'(dbg[15:0]), 32'd4);

    // Port 1 starves mid-packet while port 2 waits.
    for (int i = 0; i < 4; i++) pops[i] = 0;
    pkt(1, 2, 100, 1'b0);
    exp_pkt(1, 2, 100, 1'b0);
    pkt(2, 3, 200, 1'b1);
    for (int c = 0; c < 10 && pops[1] < 2; c++) cyc();
    chk("starve_pops", 32'(pops[1]), 32'd2);
    repeat (5) begin
      cyc();
      chk("starve_ren", 32'(s_ren), 32'd0);
    end
    chk("starve_gnt", 32'(dbg[31:24]), 32'd1);
    chk("starve_busy", 32'(s_busy), 32'd1);
    pkt(1, 2, 102, 1'b1);
    exp_pkt(1, 2, 102, 1'b1);
    exp_pkt(2, 3, 200, 1'b1);
    repeat (12) cyc();
    cmp_log("starve");

    // Backpressure with ready pattern 1,0,0,1 over a 5-word packet on port 0.
    pkt(0, 5, 300, 1'b1);
    exp_pkt(0, 5, 300, 1'b1);
    for (int c = 0; c < 30; c++) begin
      rdy_v = (pat[c % 4] != 0);
      cyc();
    end
    rdy_v = 1'b1;
    repeat (2) cyc();
    cmp_log("bp");

    // Single-word packets on ports 3 and 0 exercise the 3 -> 0 wrap.
    pkt(3, 1, 400, 1'b1);
    pkt(3, 1, 401, 1'b1);
    pkt(0, 1, 410, 1'b1);
    pkt(0, 1, 411, 1'b1);
    exp_pkt(3, 1, 400, 1'b1);
    exp_pkt(0, 1, 410, 1'b1);
    exp_pkt(3, 1, 401, 1'b1);
    exp_pkt(0, 1, 411, 1'b1);
    repeat (12) cyc();
    cmp_log("sw");
    chk("sw_gnt", 32'(dbg[31:24]), 32'd0);
    chk("sw_cnt", 32'(dbg[15:0]), 32'd11);

    // Reset after two words of a 6-word packet on port 2.
    for (int i = 0; i < 4; i++) pops[i] = 0;
    pkt(2, 6, 500, 1'b1);
    for (int c = 0; c < 20 && pops[2] < 2; c++) cyc();
    chk("mid_pops", 32'(pops[2]), 32'd2);
    rst_v = 1'b1;
    log_q.delete();
    exp_q.delete();
    pkt(0, 1, 600, 1'b1);
    repeat (2) cyc();
    chk("mid_busy", 32'(s_busy), 32'd0);
    chk("mid_ren", 32'(s_ren), 32'd0);
    chk("mid_cnt", 32'(dbg[15:0]), 32'd0);
    rst_v = 1'b0;
    exp_pkt(0, 1, 600, 1'b1);
    for (int s = 2; s < 6; s++) exp_q.push_back({2'(2), word(2, 500 + s, s == 5)});
    repeat (15) cyc();
    cmp_log("mid");
    chk("mid_cnt2", 32'(dbg[15:0]), 32'd2);
    chk("mid_empty", 32'(q[2].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rr_drain_sched.md
Name: fifo_rr_drain_sched

Overview:
- Round-robin, packet-aware scheduler that drains NPORT show-ahead FIFO read ports into one output stream.
- Each input port uses the FIFO read interface: nempty, ren, rdata. Data is valid whenever nempty=1 and is consumed on ren.
- A grant is held from first word through the EOP-marked word, so packets never interleave.
- Sits on the read clock side of a bank of async FIFOs, feeding a single downstream consumer with valid/ready flow control.

Parameters:
- NPORT, 4, number of input FIFO read ports (2..16).
- DWID, 18, FIFO data width.
- EOP_BIT, 16, bit index in rdata that marks the last word of a packet.
- PWID, 2, port index width; must equal clog2(NPORT).

Ports:
- clk  in  1  clock for all logic.
- rst  in  1  synchronous, active-high reset.
- fifo_nempty  in  NPORT  per-port "data available" flag.
- fifo_ren  out  NPORT  per-port read enable; one-hot or zero.
- fifo_rdata  in  NPORT*DWID  per-port head word; port i occupies bits [i*DWID +: DWID].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word when out_valid=1.
- out_data  out  DWID  output word.
- out_port  out  PWID  source port of out_data.
- busy  out  1  high while a grant is held (state XFER).
- dbg  out  32  {cur_gnt zero-extended to 8 bits, 8'h0, pkt_cnt[15:0]}.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high; both are already decided.
  - On rst=1 at a clk edge: state=IDLE, out_valid=0, out_data=0, out_port=0, busy=0, last_gnt=NPORT-1 (so port 0 has first priority), pkt_cnt=0.
  - fifo_ren is combinational and is 0 whenever rst=1.
  - Reset mid-packet abandons the packet. The rest of that packet stays in the FIFO and is drained as a new packet after reset.
- State IDLE:
  - Each cycle, pick the first port with fifo_nempty=1, searching from last_gnt+1 upward with wrap modulo NPORT.
  - If any port is found: cur_gnt<=picked port, state<=XFER, busy<=1.
  - No read occurs in IDLE. Arbitration costs exactly one cycle per packet.
- State XFER:
  - can_load = !out_valid || out_ready.
  - fire = fifo_nempty[cur_gnt] && can_load.
  - fifo_ren[cur_gnt] = fire; all other fifo_ren bits are 0.
  - On fire: out_data<=fifo_rdata[cur_gnt], out_port<=cur_gnt, out_valid<=1.
  - On fire with fifo_rdata[cur_gnt][EOP_BIT]=1: state<=IDLE, last_gnt<=cur_gnt, busy<=0, pkt_cnt<=pkt_cnt+1 (16-bit, wraps at 65535 to 0).
- Output register:
  - One register stage.
  - If out_valid && out_ready && !fire: out_valid<=0.
  - out_data and out_port are held stable while out_valid && !out_ready.
- Throughput and latency:
  - Streaming rate is one word per clk while the source is non-empty and out_ready=1.
  - Latency from fifo_ren to out_valid is one cycle.
- Boundary conditions:
  - Granted port goes empty mid-packet: stay in XFER with fifo_ren=0 and wait. No switch to another port, even if other ports are non-empty.
  - Backpressure: out_ready=0 with out_valid=1 means fifo_ren=0; no word is lost or duplicated.
  - Single-word packet (EOP set on the first word): XFER lasts one fire cycle, then the block returns to IDLE.
  - All ports empty in IDLE: remain in IDLE, fifo_ren=0.
  - Fairness: after a packet from port p, ports p+1..NPORT-1, then 0..p, are searched in that order.
- Invariant: fifo_ren is never asserted for a port with fifo_nempty=0.

Decomposition:
- Shared package fifo_sched_pkg holds:
  - state typedef {IDLE, XFER};
  - constant DBG_WID=32;
  - function clog2.
- One sub-module: rr_pick (combinational rotate-priority encoder).
  - Inputs: req[NPORT], last[PWID].
  - Outputs: found, idx[PWID].
  - Reused for future arbiters.

Test Plan:
- Reset: hold rst=1 with all ports non-empty → fifo_ren=0, out_valid=0, busy=0. Release rst → port 0 is granted first, with a one-cycle IDLE→XFER gap before the first fifo_ren.
- Round-robin: ports 0..3 each hold one 3-word packet, out_ready=1 → out_port sequence 0,0,0,1,1,1,2,2,2,3,3,3; one idle cycle between packets; pkt_cnt=4.
- Mid-packet starvation: port 1 provides 2 of 4 words, then empties for 5 cycles while port 2 is non-empty → no fifo_ren[2]. Port 1 refills → remaining 2 words are output, then port 2 is granted.
- Backpressure: toggle out_ready 1,0,0,1 during a 5-word packet → every word appears exactly once, in order. out_data is stable while out_valid=1 and out_ready=0.
- Single-word packets, EOP on every word, from ports 3 and 0 only → alternation 3,0,3,0; last_gnt wrap from 3 to 0 is verified.
- Reset mid-packet after word 2 of 6 on port 2 → state returns to IDLE. After release, port 0 is searched first, and port 2's remaining 4 words later drain as a new packet.
